// File: rtl/apb_fabric_pkg.sv
// Shared types and constants for the APB 1-to-N fabric.
// Imported by the fabric top and its address decoder.
package apb_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE,
        D_SETUP,
        D_ACCESS,
        RESP
    } state_t;

    // Select-field value that never maps to a slave; slave k answers to field k+1.
    localparam int unsigned UNMAPPED_FIELD = 0;

endpackage

// File: rtl/apb_fabric_decode.sv
// Slave-select decoder: maps the address select field to a slave index.
// Field values 1..NSLV hit slaves 0..NSLV-1; anything else is unmapped.
module apb_fabric_decode
    import apb_fabric_pkg::*;
#(
    parameter int unsigned NSLV  = 6,
    parameter int unsigned SEL_W = 3
) (
    input  logic [SEL_W-1:0] field,
    output logic             hit,
    output logic [SEL_W-1:0] idx
);

    localparam logic [SEL_W:0] LAST_FIELD = NSLV[SEL_W:0];

    always_comb begin
        hit = (field != SEL_W'(UNMAPPED_FIELD)) && ({1'b0, field} <= LAST_FIELD);
        idx = hit ? (field - 1'b1) : '0;
    end

endmodule

// File: rtl/apb_fabric.sv
// Registered APB 1-to-NSLV fabric with unmapped-address error response
// and a PREADY timeout watchdog; all outputs come straight from flops.
module apb_fabric
    import apb_fabric_pkg::*;
#(
    parameter int unsigned NSLV    = 6,
    parameter int unsigned AW      = 20,
    parameter int unsigned DW      = 32,
    parameter int unsigned SEL_LSB = 13,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      paddr_i,
    input  logic               pwrite_i,
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic [DW-1:0]      pwdata_i,
    output logic               pready_o,
    output logic [DW-1:0]      prdata_o,
    output logic               pslverr_o,
    output logic [NSLV-1:0]    psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [AW-1:0]      paddr_o,
    output logic [DW-1:0]      pwdata_o,
    input  logic [NSLV*DW-1:0] prdata_i,
    input  logic [NSLV-1:0]    pready_i,
    input  logic [NSLV-1:0]    pslverr_i
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state_q, state_n;
    logic [AW-1:0]    addr_q, addr_n;
    logic [DW-1:0]    wdata_q, wdata_n;
    logic             write_q, write_n;
    logic [SEL_W-1:0] idx_q, idx_n;
    logic [DW-1:0]    rdata_q, rdata_n;
    logic             err_q, err_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic             dec_hit;
    logic [SEL_W-1:0] dec_idx;
    logic             sel_ready;
    logic             sel_err;
    logic [DW-1:0]    sel_rdata;
    logic             timeout_hit;

    logic [NSLV-1:0]  psel_n;
    logic             penable_n;
    logic             pwrite_n;
    logic [AW-1:0]    paddr_n;
    logic [DW-1:0]    pwdata_n;
    logic             pready_n;
    logic [DW-1:0]    prdata_n;
    logic             pslverr_n;

    // Bits at and above the select field are latched but never forwarded downstream.
    logic             unused_addr_hi;
    assign unused_addr_hi = ^addr_q[AW-1:SEL_LSB];

    apb_fabric_decode #(
        .NSLV  (NSLV),
        .SEL_W (SEL_W)
    ) u_decode (
        .field (paddr_i[SEL_LSB +: SEL_W]),
        .hit   (dec_hit),
        .idx   (dec_idx)
    );

    // Only the latched slave's handshake is looked at; the rest are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_ready = pready_i[k];
                sel_err   = pslverr_i[k];
                sel_rdata = prdata_i[k*DW +: DW];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        write_n = write_q;
        idx_n   = idx_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        cnt_n   = cnt_q;

        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_n  = paddr_i;
                    wdata_n = pwdata_i;
                    write_n = pwrite_i;
                    if (dec_hit) begin
                        idx_n   = dec_idx;
                        state_n = D_SETUP;
                    end else begin
                        idx_n   = '0;
                        rdata_n = '0;
                        err_n   = 1'b1;
                        state_n = RESP;
                    end
                end
            end
            D_SETUP: begin
                cnt_n   = '0;
                state_n = D_ACCESS;
            end
            D_ACCESS: begin
                if (cnt_q != '1) begin
                    cnt_n = cnt_q + 1'b1;
                end
                // A ready slave on the watchdog's last cycle still counts as a normal completion.
                if (sel_ready) begin
                    rdata_n = write_q ? '0 : sel_rdata;
                    err_n   = sel_err;
                    state_n = RESP;
                end else if (timeout_hit) begin
                    rdata_n = '0;
                    err_n   = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next-state view so they line up with the state register.
    always_comb begin
        psel_n    = '0;
        penable_n = 1'b0;
        pwrite_n  = 1'b0;
        paddr_n   = '0;
        pwdata_n  = '0;
        pready_n  = 1'b0;
        prdata_n  = '0;
        pslverr_n = 1'b0;

        if (state_n == D_SETUP || state_n == D_ACCESS) begin
            for (int unsigned k = 0; k < NSLV; k++) begin
                psel_n[k] = (idx_n == SEL_W'(k));
            end
        end
        penable_n = (state_n == D_ACCESS);

        if (state_n != IDLE) begin
            pwrite_n = write_n;
            pwdata_n = wdata_n;
            for (int unsigned b = 0; b < AW; b++) begin
                paddr_n[b] = (b < SEL_LSB) ? addr_n[b] : 1'b0;
            end
        end

        if (state_n == RESP) begin
            pready_n  = 1'b1;
            prdata_n  = rdata_n;
            pslverr_n = err_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            psel_o    <= '0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pready_o  <= 1'b0;
            prdata_o  <= '0;
            pslverr_o <= 1'b0;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            write_q   <= write_n;
            idx_q     <= idx_n;
            rdata_q   <= rdata_n;
            err_q     <= err_n;
            cnt_q     <= cnt_n;
            psel_o    <= psel_n;
            penable_o <= penable_n;
            pwrite_o  <= pwrite_n;
            paddr_o   <= paddr_n;
            pwdata_o  <= pwdata_n;
            pready_o  <= pready_n;
            prdata_o  <= prdata_n;
            pslverr_o <= pslverr_n;
        end
    end

endmodule

// File: tb/tb_apb_fabric.sv
// Directed bench for apb_fabric: a cycle-timeline model predicts every output each cycle,
// plus hand-computed literal checks at the key cycles of each scenario.
module tb_apb_fabric;

    localparam int unsigned NSLV    = 6;
    localparam int unsigned AW      = 20;
    localparam int unsigned DW      = 32;
    localparam int unsigned SEL_LSB = 13;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [AW-1:0]      paddr_i;
    logic               pwrite_i;
    logic               psel_i;
    logic               penable_i;
    logic [DW-1:0]      pwdata_i;
    logic               pready_o;
    logic [DW-1:0]      prdata_o;
    logic               pslverr_o;
    logic [NSLV-1:0]    psel_o;
    logic               penable_o;
    logic               pwrite_o;
    logic [AW-1:0]      paddr_o;
    logic [DW-1:0]      pwdata_o;
    logic [NSLV*DW-1:0] prdata_i;
    logic [NSLV-1:0]    pready_i;
    logic [NSLV-1:0]    pslverr_i;

    apb_fabric #(
        .NSLV    (NSLV),
        .AW      (AW),
        .DW      (DW),
        .SEL_LSB (SEL_LSB),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .paddr_i   (paddr_i),
        .pwrite_i  (pwrite_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwdata_i  (pwdata_i),
        .pready_o  (pready_o),
        .prdata_o  (prdata_o),
        .pslverr_o (pslverr_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic [NSLV-1:0] psel;
        logic            penable;
        logic            pwrite;
        logic [AW-1:0]   paddr;
        logic [DW-1:0]   pwdata;
        logic            pready;
        logic [DW-1:0]   prdata;
        logic            pslverr;
    } exp_t;

    exp_t            exp_q[$];
    int              cyc = 0;
    int              n_tests = 0;
    int              n_fail = 0;
    int              wait_cfg[NSLV];
    logic [DW-1:0]   rdata_cfg[NSLV];
    logic [NSLV-1:0] err_cfg;

    always @(posedge clk) cyc <= cyc + 1;

    assign pslverr_i = err_cfg;
    always_comb begin
        for (int k = 0; k < NSLV; k++) prdata_i[k*DW +: DW] = rdata_cfg[k];
    end

    // Slave responder: the selected slave raises pready after wait_cfg access cycles;
    // unselected slaves keep pready high as noise the fabric has to ignore.
    initial begin
        int acc;
        acc = 0;
        pready_i = '1;
        forever begin
            @(posedge clk);
            #1;
            pready_i = '1;
            for (int k = 0; k < NSLV; k++) begin
                if (psel_o[k]) pready_i[k] = penable_o && (acc == wait_cfg[k]);
            end
            if (penable_o && psel_o != '0) acc++;
            else acc = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: derive the full per-cycle output timeline of one transfer.
    task automatic model_txn(input int t, input logic [AW-1:0] addr, input logic wr,
                             input logic [DW-1:0] wd, output int resp);
        int   f;
        int   k;
        int   n_acc;
        logic tmo;
        exp_t e;
        f = int'((addr >> SEL_LSB) & ((1 << SEL_W) - 1));
        e = '{default: '0};
        e.pwrite = wr;
        e.paddr  = addr & AW'((1 << SEL_LSB) - 1);
        e.pwdata = wd;
        if (f == 0 || f > int'(NSLV)) begin
            e.cyc     = t + 1;
            e.pready  = 1'b1;
            e.pslverr = 1'b1;
            exp_q.push_back(e);
            resp = t + 1;
        end else begin
            k     = f - 1;
            tmo   = (wait_cfg[k] >= int'(TIMEOUT));
            n_acc = tmo ? int'(TIMEOUT) : wait_cfg[k] + 1;
            e.psel    = '0;
            e.psel[k] = 1'b1;
            e.cyc     = t + 1;
            exp_q.push_back(e);
            e.penable = 1'b1;
            for (int i = 0; i < n_acc; i++) begin
                e.cyc = t + 2 + i;
                exp_q.push_back(e);
            end
            e.psel    = '0;
            e.penable = 1'b0;
            e.pready  = 1'b1;
            e.cyc     = t + 2 + n_acc;
            e.prdata  = (tmo || wr) ? '0 : rdata_cfg[k];
            e.pslverr = tmo ? 1'b1 : err_cfg[k];
            exp_q.push_back(e);
            resp = e.cyc;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        e = '{default: '0};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL stale_model_entry: entry for cycle %0d unmatched at cycle %0d", exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
        n_tests++;
        if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pready_o, prdata_o, pslverr_o} !==
            {e.psel, e.penable, e.pwrite, e.paddr, e.pwdata, e.pready, e.prdata, e.pslverr}) begin
            n_fail++;
            $display("FAIL cycle_%0d outputs: got psel=%b en=%b wr=%b addr=%h wd=%h rdy=%b rd=%h err=%b, expected psel=%b en=%b wr=%b addr=%h wd=%h rdy=%b rd=%h err=%b",
                     cyc, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pready_o, prdata_o, pslverr_o,
                     e.psel, e.penable, e.pwrite, e.paddr, e.pwdata, e.pready, e.prdata, e.pslverr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                         output int t, output int r);
        step();
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = a;
        pwrite_i  = wr;
        pwdata_i  = wd;
        t = cyc;
        model_txn(t, a, wr, wd, r);
        step();
        penable_i = 1'b1;
    endtask

    task automatic finish_txn(input int r);
        int guard;
        guard = 0;
        while (cyc < r && guard < 1000) begin
            step();
            guard++;
        end
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int t;
        int r;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        paddr_i   = '0;
        pwrite_i  = 1'b0;
        pwdata_i  = '0;
        err_cfg   = '0;
        for (int k = 0; k < NSLV; k++) begin
            wait_cfg[k]  = 0;
            rdata_cfg[k] = 32'h1111_0000 + k;
        end

        repeat (3) step();
        chk("reset_pready", pready_o, 0);
        chk("reset_psel", psel_o, 0);
        chk("reset_paddr", paddr_o, 0);
        chk("reset_prdata", prdata_o, 0);
        rst = 1'b0;
        step();

        // Zero-wait read from slave 1, other slaves report junk errors.
        rdata_cfg[1] = 32'hDEAD_BEEF;
        err_cfg      = 6'b111101;
        start(20'h04010, 1'b0, 32'h0, t, r);
        chk("t1_latency", r - t, 3);
        chk("t1_psel", psel_o, 6'b000010);
        step();
        chk("t1_penable", penable_o, 1);
        step();
        chk("t1_pready", pready_o, 1);
        chk("t1_prdata", prdata_o, 32'hDEAD_BEEF);
        chk("t1_pslverr", pslverr_o, 0);
        finish_txn(r);

        // Write to slave 5 with 3 wait states; upstream psel drops mid-transfer.
        wait_cfg[5]  = 3;
        rdata_cfg[5] = 32'hCAFE_F00D;
        err_cfg      = 6'b011111;
        start(20'h0C004, 1'b1, 32'h1234_5678, t, r);
        psel_i    = 1'b0;
        penable_i = 1'b0;
        chk("t2_latency", r - t, 6);
        chk("t2_paddr", paddr_o, 20'h00004);
        chk("t2_pwdata", pwdata_o, 32'h1234_5678);
        chk("t2_pwrite", pwrite_o, 1);
        finish_txn(r);
        chk("t2_pready", pready_o, 1);
        chk("t2_prdata", prdata_o, 0);

        // Unmapped fields 0 and 7.
        start(20'h00020, 1'b0, 32'h0, t, r);
        chk("t3a_latency", r - t, 1);
        chk("t3a_psel", psel_o, 0);
        chk("t3a_pready", pready_o, 1);
        chk("t3a_pslverr", pslverr_o, 1);
        finish_txn(r);
        start(20'h0E000, 1'b0, 32'h0, t, r);
        chk("t3b_psel", psel_o, 0);
        chk("t3b_pslverr", pslverr_o, 1);
        chk("t3b_prdata", prdata_o, 0);
        finish_txn(r);

        // Slave 2 never ready -> watchdog after 8 access cycles.
        wait_cfg[2]  = 255;
        rdata_cfg[2] = 32'h600D_F00D;
        err_cfg      = 6'b111011;
        start(20'h06008, 1'b0, 32'h0, t, r);
        chk("t4a_latency", r - t, 10);
        repeat (8) step();
        chk("t4a_psel_last_access", psel_o, 6'b000100);
        chk("t4a_penable_last_access", penable_o, 1);
        step();
        chk("t4a_psel_dropped", psel_o, 0);
        chk("t4a_pready", pready_o, 1);
        chk("t4a_pslverr", pslverr_o, 1);
        chk("t4a_prdata", prdata_o, 0);
        finish_txn(r);

        // Same slave ready on the 8th access cycle: ready beats the watchdog.
        wait_cfg[2] = 7;
        start(20'h06008, 1'b0, 32'h0, t, r);
        chk("t4b_latency", r - t, 10);
        finish_txn(r);
        chk("t4b_pready", pready_o, 1);
        chk("t4b_pslverr", pslverr_o, 0);
        chk("t4b_prdata", prdata_o, 32'h600D_F00D);

        // Slave 3 read with error flagged.
        wait_cfg[3]  = 1;
        rdata_cfg[3] = 32'hA5A5_A5A5;
        err_cfg      = 6'b001000;
        start(20'h0810C, 1'b0, 32'h0, t, r);
        finish_txn(r);
        chk("t5_pslverr", pslverr_o, 1);
        chk("t5_prdata", prdata_o, 32'hA5A5_A5A5);

        // Reset during D_ACCESS, then a normal transfer.
        wait_cfg[0] = 2;
        err_cfg     = '0;
        start(20'h02044, 1'b1, 32'hFEED_FACE, t, r);
        step();
        chk("t6_in_access", penable_o, 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_psel", psel_o, 0);
        chk("t6_rst_penable", penable_o, 0);
        chk("t6_rst_paddr", paddr_o, 0);
        chk("t6_rst_pwrite", pwrite_o, 0);
        chk("t6_rst_pwdata", pwdata_o, 0);
        psel_i    = 1'b0;
        penable_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        wait_cfg[4]  = 0;
        rdata_cfg[4] = 32'h4444_5555;
        start(20'h0A0F0, 1'b0, 32'h0, t, r);
        chk("t6_latency", r - t, 3);
        finish_txn(r);
        chk("t6_prdata", prdata_o, 32'h4444_5555);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
